// File: rtl/ring_phase_monitor_pkg.sv
// Shared FSM state and fault-code encodings for the ring phase monitor.
package ring_phase_pkg;

    localparam logic [1:0] ST_SYNC   = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [1:0] ST_FAULT  = 2'd3;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_ONEHOT = 2'b01;
    localparam logic [1:0] ERR_ORDER  = 2'b10;

endpackage

// File: rtl/ring_phase_monitor_if.sv
// Sample input and phase/status output bundle of the ring phase monitor.
interface ring_phase_monitor_if #(
    parameter int N     = 4,
    parameter int REV_W = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]     Q;
    logic             EN;
    logic [IW-1:0]    IDX;
    logic             VALID;
    logic             LOCKED;
    logic [REV_W-1:0] REV;
    logic             REV_PULSE;
    logic             ERR;
    logic [1:0]       ERR_CODE;

    modport master (
        output Q, EN,
        input  IDX, VALID, LOCKED, REV, REV_PULSE, ERR, ERR_CODE
    );

    modport slave (
        input  Q, EN,
        output IDX, VALID, LOCKED, REV, REV_PULSE, ERR, ERR_CODE
    );

endinterface

// File: rtl/ring_phase_monitor_onehot_encode.sv
// One-hot legality check and binary encoder; legal only when exactly one bit is set.
module onehot_encode #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  q_i,
    output logic          legal_o,
    output logic [IW-1:0] idx_o
);

    int ones;

    always_comb begin
        ones  = 0;
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (q_i[i]) begin
                ones  = ones + 1;
                idx_o = idx_o | IW'(i);
            end
        end
        legal_o = (ones == 1);
    end

endmodule

// File: rtl/ring_phase_monitor.sv
// Ring counter phase monitor: lock acquisition, phase index, revolution count, sticky fault.
// Optional FAULT->SYNC resync compiled in with RING_PHASE_MONITOR_AUTORESYNC_EN.
module ring_phase_monitor
    import ring_phase_pkg::*;
#(
    parameter int N        = 4,
    parameter int REV_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic CLK,
    input  logic RST,
    ring_phase_monitor_if.slave bus
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(LOCK_CNT + 1);

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    prev_q, prev_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [REV_W-1:0] rev_q, rev_d;
    logic             pulse_q, pulse_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;

    logic          legal;
    logic [IW-1:0] cur_idx;
    logic [IW-1:0] next_idx;
    logic          succ;
    logic          wrap;
    logic          hunt;
    logic [CW-1:0] run;

    onehot_encode #(.N(N)) u_enc (
        .q_i    (bus.Q),
        .legal_o(legal),
        .idx_o  (cur_idx)
    );

    assign next_idx = (prev_q == IW'(N - 1)) ? '0 : prev_q + 1'b1;
    assign succ     = legal && (cur_idx == next_idx);
    assign wrap     = (prev_q == IW'(N - 1)) && (cur_idx == '0);

    // With resync, a FAULT sample is treated exactly like a SYNC sample.
`ifdef RING_PHASE_MONITOR_AUTORESYNC_EN
    assign hunt = (state_q != ST_LOCKED);
`else
    assign hunt = (state_q == ST_SYNC) || (state_q == ST_TRACK);
`endif

    assign run = (state_q == ST_TRACK && succ) ? cnt_q + 1'b1 : CW'(1);

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        rev_d   = rev_q;
        pulse_d = 1'b0;
        err_d   = err_q;
        code_d  = code_q;
        if (bus.EN) begin
            if (state_q == ST_LOCKED) begin
                if (succ) begin
                    idx_d   = cur_idx;
                    prev_d  = cur_idx;
                    valid_d = 1'b1;
                    if (wrap) begin
                        rev_d   = rev_q + 1'b1;
                        pulse_d = 1'b1;
                    end
                end else begin
                    state_d = ST_FAULT;
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    if (!err_q)
                        code_d = legal ? ERR_ORDER : ERR_ONEHOT;
                end
            end else if (hunt) begin
                valid_d = 1'b0;
                if (!legal) begin
                    state_d = ST_SYNC;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = run;
                    prev_d = cur_idx;
                    idx_d  = cur_idx;
                    if (run >= CW'(LOCK_CNT)) begin
                        state_d = ST_LOCKED;
                        valid_d = 1'b1;
                        rev_d   = '0;
                    end else begin
                        state_d = ST_TRACK;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_SYNC;
            prev_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            rev_q   <= '0;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            rev_q   <= rev_d;
            pulse_q <= pulse_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign bus.IDX       = idx_q;
    assign bus.VALID     = valid_q;
    assign bus.LOCKED    = (state_q == ST_LOCKED);
    assign bus.REV       = rev_q;
    assign bus.REV_PULSE = pulse_q;
    assign bus.ERR       = err_q;
    assign bus.ERR_CODE  = code_q;

endmodule
